// File: rtl/s4ga_pkg.sv
// s4ga_pkg: shared helpers, index special codes and derived widths for the s4ga stream core
package s4ga_pkg;
  localparam int IDX_ZERO = 0;
  localparam int IDX_ONE = 1;
  localparam int IDX_Q = 2;
  localparam int IN_BASE = 3;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int segs(input int bits, input int w);
    return (bits + w - 1) / w;
  endfunction
  function automatic int max(input int a, input int b);
    return a > b ? a : b;
  endfunction
  function automatic int idx_w(input int n, input int i);
    return clog2(IN_BASE + i + n);
  endfunction
  function automatic int idx_segs(input int n, input int i, input int si_w);
    return segs(idx_w(n, i), si_w);
  endfunction
  function automatic int mask_segs(input int k, input int si_w);
    return segs(1 << k, si_w);
  endfunction
  function automatic int beats(input int n, input int k, input int i, input int si_w);
    return k * idx_segs(n, i, si_w) + mask_segs(k, si_w);
  endfunction
  function automatic int seg_w(input int n, input int k, input int i, input int si_w);
    return clog2(max(max(idx_segs(n, i, si_w), mask_segs(k, si_w)), 2));
  endfunction
endpackage

// File: rtl/s4ga_mask_sel.sv
// s4ga_mask_sel: picks the addressed LUT bit and half-LUT bit out of one big-endian mask segment
//   mask_seg : current mask segment, seg : its position (0 = MSB segment), ins : LUT address
//   lut_ce/lut : segment carries mask[ins] and its value; half_ce/half : same for mask[{0, ins[K-2:0]}]
module s4ga_mask_sel
  import s4ga_pkg::*;
#(
  parameter int K = 5,
  parameter int SI_W = 4,
  parameter int SEG_W = 2
) (
  input  logic [SI_W-1:0]  mask_seg,
  input  logic [SEG_W-1:0] seg,
  input  logic [K-1:0]     ins,
  output logic             lut_ce,
  output logic             lut,
  output logic             half_ce,
  output logic             half
);
  localparam int MASK_SEGS = mask_segs(K, SI_W);
  localparam int FW = MASK_SEGS * SI_W;
  logic [FW-1:0] full;
  logic [K-1:0] ha;
  // Place the segment at its bit position in a full-width mask so plain indexing selects the bit.
  always_comb begin
    full = FW'(mask_seg) << ((MASK_SEGS - 1 - int'(seg)) * SI_W);
    ha = {1'b0, ins[K-2:0]};
    lut_ce = int'(ins) / SI_W == MASK_SEGS - 1 - int'(seg);
    half_ce = int'(ha) / SI_W == MASK_SEGS - 1 - int'(seg);
    lut = full[ins];
    half = full[ha];
  end
endmodule

// File: rtl/s4ga_stream.sv
// s4ga_stream: streamed K-LUT fabric evaluating one LUT per configuration record, N LUTs per frame
//   si_valid/si/sof : configuration beats, sof marks the first beat of a frame
//   inputs : fabric inputs; outputs : last O LUT results of the latest complete frame
//   frame_done : completion pulse; err : sticky error; debug : decoded inputs and LUT results
module s4ga_stream
  import s4ga_pkg::*;
#(
  parameter int N = 89,
  parameter int K = 5,
  parameter int I = 2,
  parameter int O = 7,
  parameter int SI_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            si_valid,
  input  logic [SI_W-1:0] si,
  input  logic            sof,
  input  logic [I-1:0]    inputs,
  output logic [O-1:0]    outputs,
  output logic            frame_done,
  output logic            err,
  output logic            debug
);
  localparam int IDX_SEGS = idx_segs(N, I, SI_W);
  localparam int MASK_SEGS = mask_segs(K, SI_W);
  localparam int AW = IDX_SEGS * SI_W;
  localparam int N_W = clog2(N);
  localparam int K_W = clog2(K + 1);
  localparam int SEG_W = seg_w(N, K, I, SI_W);
  logic [N_W-1:0] n, n_e, n_d;
  logic [K_W-1:0] k, k_e, k_d;
  logic [SEG_W-1:0] seg, seg_e, seg_d;
  logic [AW-1:0] acc, acc_d, idx_v;
  logic [K-1:0] ins, ins_d;
  logic [N-1:0] luts, luts_d;
  logic [O-1:0] outs_d;
  logic q, q_d, lut_r, lut_d, half_r, half_d, fd_d, err_d, dbg_d;
  logic mask_ph, last_seg, dv, oor, lut_f, half_f;
  logic lut_ce, lut_c, half_ce, half_c;
  // A sof beat is processed as if the counters were already at the frame start.
  assign n_e = sof ? '0 : n;
  assign k_e = sof ? '0 : k;
  assign seg_e = sof ? '0 : seg;
  s4ga_mask_sel #(.K(K), .SI_W(SI_W), .SEG_W(SEG_W)) u_sel (
    .mask_seg(si),
    .seg(seg_e),
    .ins(ins),
    .lut_ce(lut_ce),
    .lut(lut_c),
    .half_ce(half_ce),
    .half(half_c)
  );
  always_comb begin
    idx_v = (acc << SI_W) | AW'(si);
    mask_ph = k_e == K_W'(K);
    last_seg = mask_ph ? seg_e == SEG_W'(MASK_SEGS - 1) : seg_e == SEG_W'(IDX_SEGS - 1);
    oor = int'(idx_v) >= IN_BASE + I + N;
    dv = 1'b0;
    if (int'(idx_v) == IDX_ONE) dv = 1'b1;
    if (int'(idx_v) == IDX_Q) dv = q;
    for (int j = 0; j < I; j++) if (int'(idx_v) == IN_BASE + j) dv = inputs[j];
    for (int j = 0; j < N; j++) if (int'(idx_v) == IN_BASE + I + j) dv = luts[j];
    lut_f = lut_ce ? lut_c : lut_r;
    half_f = half_ce ? half_c : half_r;
    n_d = n;
    k_d = k;
    seg_d = seg;
    acc_d = acc;
    ins_d = ins;
    q_d = q;
    luts_d = luts;
    lut_d = lut_r;
    half_d = half_r;
    outs_d = outputs;
    fd_d = 1'b0;
    dbg_d = 1'b0;
    err_d = err;
    if (si_valid) begin
      err_d = err | (sof && (n != '0 || k != '0 || seg != '0));
      n_d = n_e;
      k_d = k_e;
      seg_d = last_seg ? '0 : seg_e + SEG_W'(1);
      if (!mask_ph) begin
        acc_d = idx_v;
        if (last_seg) begin
          ins_d = {ins[K-2:0], dv};
          k_d = k_e + K_W'(1);
          dbg_d = dv;
          err_d = err_d | oor;
        end
      end else begin
        lut_d = lut_f;
        half_d = half_f;
        if (last_seg) begin
          luts_d = {luts[N-2:0], lut_f};
          q_d = half_f;
          k_d = '0;
          n_d = n_e == N_W'(N - 1) ? '0 : n_e + N_W'(1);
          dbg_d = lut_f;
          fd_d = n_e == N_W'(N - 1);
          outs_d = fd_d ? luts_d[O-1:0] : outputs;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n <= '0;
      k <= '0;
      seg <= '0;
      acc <= '0;
      ins <= '0;
      q <= 1'b0;
      luts <= '0;
      lut_r <= 1'b0;
      half_r <= 1'b0;
      outputs <= '0;
      frame_done <= 1'b0;
      err <= 1'b0;
      debug <= 1'b0;
    end else begin
      n <= n_d;
      k <= k_d;
      seg <= seg_d;
      acc <= acc_d;
      ins <= ins_d;
      q <= q_d;
      luts <= luts_d;
      lut_r <= lut_d;
      half_r <= half_d;
      outputs <= outs_d;
      frame_done <= fd_d;
      err <= err_d;
      debug <= dbg_d;
    end
  end
endmodule
